// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: counter encodings and saturating-counter helper shared by the predictor
package branch_predictor_pkg;
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;
  localparam ctr_e CTR_RESET = CTR_WNT;
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    return taken ? ((ctr == CTR_ST) ? ctr : ctr + 2'd1) : ((ctr == CTR_SNT) ? ctr : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and resolver feedback bundle
interface branch_predictor_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] fetch_pc_in;
  logic                  pred_out;
  logic [DATA_WIDTH-1:0] pred_target_out;
  logic                  feedback_in;
  logic [DATA_WIDTH-1:0] update_pc_in;
  logic                  taken_in;
  logic [DATA_WIDTH-1:0] update_target_in;
  logic                  mispredict_in;
  logic [15:0]           mispredict_count_out;
  modport master (
    output fetch_pc_in, feedback_in, update_pc_in, taken_in, update_target_in, mispredict_in,
    input  pred_out, pred_target_out, mispredict_count_out
  );
  modport slave (
    input  fetch_pc_in, feedback_in, update_pc_in, taken_in, update_target_in, mispredict_in,
    output pred_out, pred_target_out, mispredict_count_out
  );
endinterface

// File: rtl/bp_entry_table.sv
// bp_entry_table: direction counters plus direct-mapped target buffer, async read, one sync write
module bp_entry_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS   = 4,
  parameter int TAG_BITS   = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_target,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic [IDX_BITS-1:0]   wr_idx,
  input  logic                  wr_taken,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_target
);
  localparam int ENTRIES = 1 << IDX_BITS;
  logic [ENTRIES-1:0]    valid;
  logic [TAG_BITS-1:0]   tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] target [ENTRIES];
  logic [1:0]            ctr    [ENTRIES];
  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tag[rd_idx];
  assign rd_target = target[rd_idx];
  assign rd_ctr    = ctr[rd_idx];
  // Counters train on every outcome regardless of tag; only taken outcomes allocate.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_RESET;
      end
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_ctr_next(ctr[wr_idx], wr_taken);
      if (wr_taken) begin
        valid[wr_idx]  <= 1'b1;
        tag[wr_idx]    <= wr_tag;
        target[wr_idx] <= wr_target;
      end
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side 2-bit predictor with target buffer, registered training and mispredict stats
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 4
) (
  input logic clk_in,
  input logic rst_n_in,
  branch_predictor_if.slave bp
);
  localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;
  logic                  upd_valid;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic [DATA_WIDTH-1:0] upd_pc;
  logic [DATA_WIDTH-1:0] upd_target;
  logic [15:0]           mis_cnt;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_target;
  logic [1:0]            rd_ctr;
  // Payload only loads on a strobe so idle-cycle X on the update bus never reaches the table.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      upd_valid      <= 1'b0;
      upd_taken      <= 1'b0;
      upd_mispredict <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
      mis_cnt        <= '0;
    end else begin
      upd_valid <= bp.feedback_in;
      if (bp.feedback_in) begin
        upd_taken      <= bp.taken_in;
        upd_mispredict <= bp.mispredict_in;
        upd_pc         <= bp.update_pc_in;
        upd_target     <= bp.update_target_in;
      end
      if (upd_valid && upd_mispredict && mis_cnt != 16'hFFFF)
        mis_cnt <= mis_cnt + 16'd1;
    end
  end
  bp_entry_table #(
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_table (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rd_idx   (bp.fetch_pc_in[IDX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_target(rd_target),
    .rd_ctr   (rd_ctr),
    .wr_en    (upd_valid),
    .wr_idx   (upd_pc[IDX_BITS+1:2]),
    .wr_taken (upd_taken),
    .wr_tag   (upd_pc[DATA_WIDTH-1:IDX_BITS+2]),
    .wr_target(upd_target)
  );
  assign bp.pred_out             = rd_valid && rd_tag == bp.fetch_pc_in[DATA_WIDTH-1:IDX_BITS+2] && rd_ctr[1];
  assign bp.pred_target_out      = bp.pred_out ? rd_target : '0;
  assign bp.mispredict_count_out = mis_cnt;
endmodule
